r_div_iter: RTL

// - Iterative restoring divider FU for the PE, with valid/ready handshakes on both sides.
// - Signed and unsigned division; retires LOG2_RADIX quotient bits per cycle.
// - Defined results for divide-by-zero and signed overflow; registered quotient and remainder.
// - Used as the divide functional unit alongside the other PE FUs.

---
 rtl/pea_pkg.sv | 14 +
 rtl/r_div_step.sv | 37 +++
 rtl/r_div_iter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pea_pkg.sv
// Shared PE definitions: divider sizing and divider FSM state encoding.
package pea_pkg;

  localparam int DIV_WIDTH      = 32;
  localparam int DIV_LOG2_RADIX = 2;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/r_div_step.sv
// One iteration of the restoring divider: LOG2_RADIX chained shift/trial-subtract
// cells, retiring quotient bits MSB-first.
module r_div_step #(
  parameter int WIDTH      = 32,
  parameter int LOG2_RADIX = 2
) (
  input  logic [WIDTH:0]        i_rem,
  input  logic [LOG2_RADIX-1:0] i_bits,
  input  logic [WIDTH-1:0]      i_divisor,
  output logic [WIDTH:0]        o_rem,
  output logic [LOG2_RADIX-1:0] o_q
);

  logic [WIDTH:0]        w_rem;
  logic [WIDTH:0]        w_trial;
  logic [LOG2_RADIX-1:0] w_q;

  // The remainder stays below the divisor, so the shifted value plus the
  // trial difference always fit in WIDTH+1 bits and bit WIDTH is the sign.
  always_comb begin
    w_rem   = i_rem;
    w_trial = '0;
    w_q     = '0;
    for (int k = LOG2_RADIX - 1; k >= 0; k--) begin
      w_rem   = {w_rem[WIDTH-1:0], i_bits[k]};
      w_trial = w_rem - {1'b0, i_divisor};
      if (!w_trial[WIDTH]) begin
        w_rem  = w_trial;
        w_q[k] = 1'b1;
      end
    end
  end

  assign o_rem = w_rem;
  assign o_q   = w_q;

endmodule

// File: rtl/r_div_iter.sv
// Iterative restoring divider FU: signed/unsigned, LOG2_RADIX quotient bits per
// cycle, defined divide-by-zero result, registered outputs behind valid/ready.
module r_div_iter
  import pea_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int LOG2_RADIX = DIV_LOG2_RADIX
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output div_state_e       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops and data never changes until that transfer.

  localparam int N_ITER = WIDTH / LOG2_RADIX;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER - 1);

  div_state_e            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_dvd;
  logic [WIDTH-1:0]      r_dvs;
  logic [WIDTH:0]        r_rem;
  logic [WIDTH-1:0]      r_quo;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_valid;
  logic [WIDTH-1:0]      r_quotient;
  logic [WIDTH-1:0]      r_remainder;
  logic                  r_dbz;

  logic                  w_dvd_neg;
  logic                  w_dvs_neg;
  logic [WIDTH-1:0]      w_dvd_abs;
  logic [WIDTH-1:0]      w_dvs_abs;
  logic [WIDTH:0]        w_step_rem;
  logic [LOG2_RADIX-1:0] w_step_q;
  logic [WIDTH+LOG2_RADIX-1:0] w_qcat;
  logic                  w_accept;

  assign w_dvd_neg = signed_i & dividend_i[WIDTH-1];
  assign w_dvs_neg = signed_i & divisor_i[WIDTH-1];
  // Negating MIN wraps back to MIN, which read unsigned is the right magnitude.
  assign w_dvd_abs = w_dvd_neg ? -dividend_i : dividend_i;
  assign w_dvs_abs = w_dvs_neg ? -divisor_i : divisor_i;
  assign w_accept  = valid_i & ready_o;
  assign w_qcat    = {r_quo, w_step_q};

  r_div_step #(
    .WIDTH      (WIDTH),
    .LOG2_RADIX (LOG2_RADIX)
  ) u_step (
    .i_rem     (r_rem),
    .i_bits    (r_dvd[WIDTH-1 -: LOG2_RADIX]),
    .i_divisor (r_dvs),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= DIV_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_valid     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            if (divisor_i == '0) begin
              r_quotient  <= '1;
              r_remainder <= dividend_i;
              r_dbz       <= 1'b1;
              r_valid     <= 1'b1;
              r_state     <= DIV_DONE;
            end else begin
              r_dvd   <= w_dvd_abs;
              r_dvs   <= w_dvs_abs;
              r_neg_q <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r <= w_dvd_neg;
              r_rem   <= '0;
              r_quo   <= '0;
              r_cnt   <= CNT_LOAD;
              r_state <= DIV_ITER;
            end
          end
        end
        DIV_ITER: begin
          r_rem <= w_step_rem;
          r_quo <= w_qcat[WIDTH-1:0];
          r_dvd <= r_dvd << LOG2_RADIX;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          r_quotient  <= r_neg_q ? -r_quo : r_quo;
          r_remainder <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
          r_dbz       <= 1'b0;
          r_valid     <= 1'b1;
          r_state     <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_state <= DIV_IDLE;
          end
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign ready_o       = (r_state == DIV_IDLE) & ~rst_i;
  assign valid_o       = r_valid;
  assign quotient_o    = r_quotient;
  assign remainder_o   = r_remainder;
  assign div_by_zero_o = r_dbz;
  assign dbg_state_o   = r_state;

endmodule
